scu_mapper_seq: RTL and testbench

- Sequential, configurable successor to the combinational SCU mapper. Maps (out_idx, in_idx) to (SCU row, SCU col, linear index) for a POF x PIF SCU array.
- Layer geometry is latched once per layer through a config handshake. Two shared serial dividers replace combinational dividers.
- Adds an interleaved (modulo) mapping mode, saturation flagging, config error detection, and valid/ready handshakes on request and response.

---
 rtl/scu_mapper_seq.sv | 196 +++++++++++++++++++
 tb/tb_scu_mapper_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scu_mapper_seq.sv
// Sequential SCU mapper: config-latched geometry, two shared serial dividers.
// Optional SCU_MAPPER_STATS_EN adds a saturating sat_count output.
module scu_mapper_seq #(
  parameter int POF       = 4,
  parameter int PIF       = 12,
  parameter int IDX_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [IDX_WIDTH-1:0]         cfg_out_ch,
  input  logic [IDX_WIDTH-1:0]         cfg_in_ch,
  input  logic                         cfg_mode,
  output logic                         cfg_done,
  output logic                         cfg_err,
  output logic                         configured,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [IDX_WIDTH-1:0]         req_out_idx,
  input  logic [IDX_WIDTH-1:0]         req_in_idx,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [$clog2(POF)-1:0]       scu_row,
  output logic [$clog2(PIF)-1:0]       scu_col,
  output logic [$clog2(POF*PIF)-1:0]   scu_linear,
  output logic                         resp_sat
`ifdef SCU_MAPPER_STATS_EN
  ,
  output logic [IDX_WIDTH-1:0]         sat_count
`endif
);

  localparam int D    = IDX_WIDTH + 1;
  localparam int RW   = $clog2(POF);
  localparam int CW   = $clog2(PIF);
  localparam int LW   = $clog2(POF*PIF);
  localparam int CNTW = $clog2(D+1);

  typedef enum logic [2:0] {
    UNCONF, CFG_DIV, READY, MAP_DIV, FIN, RESP
  } state_t;

  state_t state_q, state_d;

  logic                 mode_q;
  logic [IDX_WIDTH-1:0] out_per_row;
  logic [IDX_WIDTH-1:0] in_per_col;
  logic [CNTW-1:0]      cnt_q;

  // lane 0 works on rows, lane 1 on columns
  logic [1:0][D-1:0]    dq, dr, dd;
  logic [1:0][D-1:0]    dq_nx, dr_nx;
  logic [1:0][D:0]      sh;
  logic [1:0]           ge;

  logic cfg_fire, cfg_bad, req_fire, resp_fire, div_last;

  logic [D-1:0]  row_raw, col_raw;
  logic          row_clamp, col_clamp;
  logic [RW-1:0] row_v;
  logic [CW-1:0] col_v;

  assign cfg_bad   = (cfg_out_ch == '0) || (cfg_in_ch == '0);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign req_fire  = req_valid && req_ready;
  assign resp_fire = resp_valid && resp_ready;
  assign div_last  = (cnt_q == CNTW'(D-1));

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      sh[k]    = {dr[k], dq[k][D-1]};
      ge[k]    = sh[k] >= {1'b0, dd[k]};
      dr_nx[k] = ge[k] ? (sh[k][D-1:0] - dd[k]) : sh[k][D-1:0];
      dq_nx[k] = {dq[k][D-2:0], ge[k]};
    end
  end

  always_comb begin
    row_raw   = mode_q ? dr[0] : dq[0];
    col_raw   = mode_q ? dr[1] : dq[1];
    row_clamp = !mode_q && (row_raw >= D'(POF));
    col_clamp = !mode_q && (col_raw >= D'(PIF));
    row_v     = row_clamp ? RW'(POF-1) : row_raw[RW-1:0];
    col_v     = col_clamp ? CW'(PIF-1) : col_raw[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= UNCONF;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cfg_ready  = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      UNCONF: begin
        cfg_ready = 1'b1;
        if (cfg_valid && !cfg_bad) state_d = CFG_DIV;
      end
      CFG_DIV: if (div_last) state_d = READY;
      READY: begin
        cfg_ready = 1'b1;
        req_ready = !cfg_valid;
        if (cfg_valid) begin
          if (!cfg_bad) state_d = CFG_DIV;
        end else if (req_valid) begin
          state_d = MAP_DIV;
        end
      end
      MAP_DIV: if (div_last) state_d = FIN;
      FIN:     state_d = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = READY;
      end
      default: state_d = UNCONF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= 1'b0;
      configured  <= 1'b0;
      out_per_row <= '0;
      in_per_col  <= '0;
      cnt_q       <= '0;
      dq          <= '0;
      dr          <= '0;
      dd          <= '0;
      cfg_done    <= 1'b0;
      cfg_err     <= 1'b0;
      scu_row     <= '0;
      scu_col     <= '0;
      scu_linear  <= '0;
      resp_sat    <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      if (cfg_fire) begin
        if (cfg_bad) begin
          cfg_err <= 1'b1;
        end else begin
          // ceil-divide the channel counts by the array size
          dq[0]      <= {1'b0, cfg_out_ch} + D'(POF-1);
          dq[1]      <= {1'b0, cfg_in_ch} + D'(PIF-1);
          dd[0]      <= D'(POF);
          dd[1]      <= D'(PIF);
          dr         <= '0;
          cnt_q      <= '0;
          mode_q     <= cfg_mode;
          configured <= 1'b0;
        end
      end else if (req_fire) begin
        dq[0] <= {1'b0, req_out_idx};
        dq[1] <= {1'b0, req_in_idx};
        dd[0] <= mode_q ? D'(POF) : {1'b0, out_per_row};
        dd[1] <= mode_q ? D'(PIF) : {1'b0, in_per_col};
        dr    <= '0;
        cnt_q <= '0;
      end
      if (state_q == CFG_DIV || state_q == MAP_DIV) begin
        dq    <= dq_nx;
        dr    <= dr_nx;
        cnt_q <= cnt_q + CNTW'(1);
        if (state_q == CFG_DIV && div_last) begin
          out_per_row <= dq_nx[0][IDX_WIDTH-1:0];
          in_per_col  <= dq_nx[1][IDX_WIDTH-1:0];
          configured  <= 1'b1;
          cfg_done    <= 1'b1;
        end
      end
      if (state_q == FIN) begin
        scu_row    <= row_v;
        scu_col    <= col_v;
        scu_linear <= LW'(32'(row_v) * PIF + 32'(col_v));
        resp_sat   <= row_clamp || col_clamp;
      end
    end
  end

`ifdef SCU_MAPPER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (cfg_fire && !cfg_bad) begin
      sat_count <= '0;
    end else if (resp_fire && resp_sat && sat_count != '1) begin
      sat_count <= sat_count + IDX_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_scu_mapper_seq.sv
// Scoreboard bench for scu_mapper_seq: random configs/requests vs a
// division-rule reference model, plus directed handshake and reset cases.
module tb_scu_mapper_seq;

  localparam int POF = 4;
  localparam int PIF = 12;
  localparam int IW  = 16;
  localparam int D   = IW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [IW-1:0] cfg_out_ch = '0;
  logic [IW-1:0] cfg_in_ch = '0;
  logic          cfg_mode = 1'b0;
  logic          cfg_done, cfg_err, configured;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [IW-1:0] req_out_idx = '0;
  logic [IW-1:0] req_in_idx = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [1:0]    scu_row;
  logic [3:0]    scu_col;
  logic [5:0]    scu_linear;
  logic          resp_sat;
`ifdef SCU_MAPPER_STATS_EN
  logic [IW-1:0] sat_count;
`endif

  scu_mapper_seq #(.POF(POF), .PIF(PIF), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_out_ch(cfg_out_ch), .cfg_in_ch(cfg_in_ch), .cfg_mode(cfg_mode),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .configured(configured),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_out_idx(req_out_idx), .req_in_idx(req_in_idx),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .scu_row(scu_row), .scu_col(scu_col), .scu_linear(scu_linear),
    .resp_sat(resp_sat)
`ifdef SCU_MAPPER_STATS_EN
    , .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int row;
    int col;
    int lin;
    int sat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int   m_opr, m_ipc, m_mode, m_conf, m_satcnt;
  int   bp = 0;

  function automatic void check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endfunction

  function automatic exp_t ref_map(input int o, input int i);
    exp_t e;
    e.sat = 0;
    if (m_mode != 0) begin
      e.row = o % POF;
      e.col = i % PIF;
    end else begin
      e.row = o / m_opr;
      e.col = i / m_ipc;
      if (e.row > POF - 1) begin e.row = POF - 1; e.sat = 1; end
      if (e.col > PIF - 1) begin e.col = PIF - 1; e.sat = 1; end
    end
    e.lin = e.row * PIF + e.col;
    return e;
  endfunction

  // backpressure driver: 0 always ready, 1 random, 2 held low
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp == 0)      resp_ready = 1'b1;
      else if (bp == 1) resp_ready = ($urandom % 3) != 0;
      else              resp_ready = 1'b0;
    end
  end

  // monitor: pops one expectation per response handshake
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("row", int'(scu_row), e.row);
        check("col", int'(scu_col), e.col);
        check("linear", int'(scu_linear), e.lin);
        check("sat", int'(resp_sat), e.sat);
        if (e.sat != 0 && m_satcnt < 65535) m_satcnt++;
      end
    end
  end

  task automatic wait_sig(input int sel, input string nm);
    int n = 0;
    forever begin
      @(negedge clk);
      if (sel == 0 && cfg_ready) break;
      if (sel == 1 && req_ready) break;
      if (sel == 2 && resp_valid) break;
      n++;
      if (n > 300) begin
        check({nm, "_timeout"}, 0, 1);
        break;
      end
    end
  endtask

  task automatic do_cfg(input int o, input int i, input int m);
    int n;
    wait_sig(0, "cfg_ready");
    cfg_out_ch = IW'(o);
    cfg_in_ch  = IW'(i);
    cfg_mode   = m[0];
    cfg_valid  = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    if (o == 0 || i == 0) begin
      check("cfg_err", int'(cfg_err), 1);
      check("cfg_err_conf", int'(configured), m_conf);
    end else begin
      m_opr = (o + POF - 1) / POF;
      m_ipc = (i + PIF - 1) / PIF;
      m_mode = m;
      m_conf = 0;
      m_satcnt = 0;
      n = 0;
      while (!cfg_done && n < 100) begin
        @(posedge clk);
        #1 n++;
      end
      check("cfg_lat_ok", int'(n == D || n == D + 1), 1);
      check("cfg_configured", int'(configured), 1);
      m_conf = 1;
    end
  endtask

  task automatic issue_req(input int o, input int i);
    wait_sig(1, "req_ready");
    req_out_idx = IW'(o);
    req_in_idx  = IW'(i);
    req_valid   = 1'b1;
    @(posedge clk);
    exp_q.push_back(ref_map(o, i));
    #1 req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    if (exp_q.size() != 0) begin
      check({nm, "_drain_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic do_req(input int o, input int i);
    int n = 0;
    issue_req(o, i);
    while (!resp_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    check("resp_lat", n, D + 1);
    drain("req");
`ifdef SCU_MAPPER_STATS_EN
    check("sat_count", int'(sat_count), m_satcnt);
`endif
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, "_flags"},
          int'({resp_valid, cfg_done, cfg_err, configured, req_ready, resp_sat}), 0);
    check({nm, "_data"}, int'({scu_row, scu_col, scu_linear}), 0);
    check({nm, "_cfg_ready"}, int'(cfg_ready), 1);
  endtask

  initial begin
    int o, i, oc, ic, hold;
    m_opr = 1; m_ipc = 1; m_mode = 0; m_conf = 0; m_satcnt = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_outs("reset");
    rst = 1'b0;

    // bad config while unconfigured
    do_cfg(0, 5, 0);

    // block mapping
    do_cfg(64, 96, 0);
    do_req(37, 50);

    // saturation
    do_cfg(10, 96, 0);
    do_req(13, 95);

    // interleaved mapping
    do_cfg(64, 96, 1);
    do_req(37, 50);

    // rejected config keeps the old geometry
    do_cfg(64, 0, 0);
    do_req(37, 50);

    // backpressure: outputs held, no new work accepted
    bp = 2;
    resp_ready = 1'b0;
    issue_req(5, 7);
    wait_sig(2, "bp_resp");
    hold = int'({resp_sat, scu_row, scu_col, scu_linear});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_stable", int'({resp_sat, scu_row, scu_col, scu_linear}), hold);
      check("bp_req_ready", int'(req_ready), 0);
      check("bp_cfg_ready", int'(cfg_ready), 0);
    end
    bp = 0;
    drain("bp");

    // config and request together: config wins
    wait_sig(1, "prio_ready");
    cfg_out_ch = 16'd64; cfg_in_ch = 16'd96; cfg_mode = 1'b0; cfg_valid = 1'b1;
    req_out_idx = 16'd1; req_in_idx = 16'd1; req_valid = 1'b1;
    #1 check("prio_req_ready", int'(req_ready), 0);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    req_valid = 1'b0;
    check("prio_cfg_taken", int'(configured), 0);
    m_opr = 16; m_ipc = 8; m_mode = 0; m_satcnt = 0;
    begin
      int n = 0;
      while (!cfg_done && n < 100) begin
        @(posedge clk);
        #1 n++;
      end
      check("prio_cfg_done", int'(cfg_done), 1);
    end
    m_conf = 1;
    do_req(63, 95);

    // randomized phase
    bp = 1;
    oc = 64; ic = 96;
    for (int t = 0; t < 40; t++) begin
      if ($urandom % 4 == 0) begin
        if ($urandom % 6 == 0) begin
          do_cfg(0, $urandom_range(0, 50), int'($urandom % 2));
        end else begin
          if ($urandom % 5 == 0) begin
            oc = $urandom_range(1, 65535);
            ic = $urandom_range(1, 65535);
          end else begin
            oc = $urandom_range(1, 400);
            ic = $urandom_range(1, 400);
          end
          do_cfg(oc, ic, int'($urandom % 2));
        end
      end
      o = $urandom_range(0, (oc + oc / 4 + 8 > 65535) ? 65535 : oc + oc / 4 + 8);
      i = $urandom_range(0, (ic + ic / 4 + 8 > 65535) ? 65535 : ic + ic / 4 + 8);
      do_req(o, i);
    end
    bp = 0;

    // reset in the middle of a division
    issue_req(20, 30);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 check_reset_outs("midreset");
    exp_q.delete();
    m_conf = 0;
    m_satcnt = 0;
    rst = 1'b0;
    req_out_idx = 16'd3; req_in_idx = 16'd3; req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("unconf_req_ready", int'(req_ready), 0);
    end
    req_valid = 1'b0;
    do_cfg(64, 96, 0);
    do_req(37, 50);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
